sub_bytes_seq: RTL and testbench
================================

SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 4, giving the number of S-box lookups per clock; legal values are 1, 2, 4, 8 and 16, and any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream block is presenting a state.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-006 SHALL have port in_data, input, 128 bits: the AES state in row-major order; bits [127:96] are row 0 and byte i is in_data[127-8i -: 8].
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a completed SubBytes result.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream ShiftRow/round stage is taking the result.
REQ-009 SHALL have port out_data, output, 128 bits: the SubBytes result, with the same byte layout as in_data.
REQ-010 SHALL have port busy, output, 1 bit: high while the block is in the BUSY state.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, BUSY and DONE; N = 16/BYTES_PER_CYCLE.
REQ-012 SHALL drive in_ready = 1 only in IDLE with rst_n high; busy = 1 only in BUSY; out_valid = 1 only in DONE.
REQ-013 SHALL, in IDLE on an edge with in_valid && in_ready, load in_data into the internal state register, clear the chunk counter to 0 and go to BUSY.
REQ-014 SHALL, in BUSY on each edge, replace bytes [k*BPC, k*BPC+BPC-1] of the state register with their FIPS-197 S-box images, where k is the counter value and BPC is BYTES_PER_CYCLE, and then increment k.
REQ-015 SHALL leave all other bytes of the state register unchanged during a BUSY update.
REQ-016 SHALL move from BUSY to DONE on the edge that processes chunk k = N-1, so that out_valid rises exactly N edges after the accepting edge (4 at the default).
REQ-017 SHALL use a chunk counter of width clog2(N) (minimum 1 bit) that never wraps past N-1.
REQ-018 SHALL drive out_data directly from the state register; it is meaningful only while out_valid = 1.
REQ-019 SHALL, in DONE with out_ready = 0, hold out_data and out_valid stable for any number of cycles.
REQ-020 SHALL, in DONE on an edge with out_ready = 1, go to IDLE; in_ready is high in the following cycle, with no bypass from DONE back to BUSY.
REQ-021 SHALL ignore in_valid outside IDLE; in_data is not sampled in BUSY or DONE.
REQ-022 SHALL have out_ready asserted outside DONE cause no state change.
REQ-023 SHALL compute the S-box combinationally from in-module logic (table or GF(2^8) inverse plus affine transform), with no extra pipeline register inside the S-box path.
REQ-024 SHALL sustain a throughput of one state per N+2 cycles when out_ready is held high.

Reset
REQ-025 SHALL, on an edge with rst_n = 0, force the state to IDLE, the counter to 0 and the state register to 0, from any state.
REQ-026 SHALL hold in_ready = 0, out_valid = 0 and busy = 0 while rst_n = 0, with out_data = 0 from the first reset edge.
REQ-027 SHALL abort any operation in BUSY or DONE when reset is applied, never emit a partially processed result, and accept a fresh state from the first cycle after rst_n returns high.

Verification
REQ-028 SHALL pass: BPC=4, in_data 128'h00112233445566778899aabbccddeeff accepted, out_ready=1 -> out_valid high 4 edges later with out_data 128'h638293c31bfc33f5c4eeacea4bc12816.
REQ-029 SHALL pass: all 256 byte values sent as 16 states with BPC in {1, 16} -> every byte matches FIPS-197 (S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16), with latency 16 and 1 respectively.
REQ-030 SHALL pass: result in DONE with out_ready=0 for 10 cycles and in_valid=1 carrying new data -> out_data unchanged, in_ready=0, the new data not consumed; out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-031 SHALL pass: rst_n driven low for one edge at counter k=2 in BUSY -> next cycle in IDLE with out_valid=0, out_data=0 and busy=0; a subsequent all-zero state -> out_data all bytes 0x63.
REQ-032 SHALL pass: back-to-back states with in_valid and out_ready held high -> one result every N+2 cycles, results in order, none dropped or duplicated.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: a 128-bit state is substituted BYTES_PER_CYCLE bytes per clock.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   data_q, data_d;
    logic [6:0]     lsb;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as b^254 (0 maps to 0), followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = b;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lsb     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    lsb = 7'(8 * (15 - (int'(cnt_q) * BYTES_PER_CYCLE + j)));
                    data_d[lsb +: 8] = sbox(data_q[lsb +: 8]);
                end
                // Counter parks at the last chunk instead of wrapping.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = rst_n && (state_q == BUSY);
    assign out_valid = rst_n && (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (4, 1 and 16 bytes per cycle) checked
// against an S-box table built from GF(2^8) inverse search and the affine rule.
module tb_sub_bytes_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         in_valid[3];
    logic         in_ready[3];
    logic [127:0] in_data[3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic [127:0] out_data[3];
    logic         busy[3];
    logic         gap_on[3];
    int           pend[3];
    int           rx_cnt[3];

    logic [7:0] sbox_tab[256];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                       inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] st);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8 * (15 - b) +: 8] = sbox_tab[st[8 * (15 - b) +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int B = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        localparam int N = 16 / B;
        logic [127:0] exp_q[$];
        int           lat_q[$];
        logic         prev_ov = 1'b0;
        int           last_hs = -1;

        sub_bytes_seq #(.BYTES_PER_CYCLE(B)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                lat_q.delete();
                prev_ov = 1'b0;
                last_hs = -1;
            end else begin
                if (in_valid[g] && in_ready[g]) begin
                    exp_q.push_back(ref_sub(in_data[g]));
                    lat_q.push_back(cyc);
                end
                if (out_valid[g] && !prev_ov) begin
                    if (lat_q.size() == 0) fail($sformatf("u%0d_spurious_out", g));
                    else chk($sformatf("u%0d_latency", g), 128'(cyc - lat_q.pop_front() - 1), 128'(N));
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q.size() == 0) fail($sformatf("u%0d_unexpected_result", g));
                    else chk($sformatf("u%0d_data", g), out_data[g], exp_q.pop_front());
                    rx_cnt[g]++;
                    if (gap_on[g] && last_hs >= 0)
                        chk($sformatf("u%0d_gap", g), 128'(cyc - last_hs), 128'(N + 2));
                    last_hs = gap_on[g] ? cyc : -1;
                end
                prev_ov = out_valid[g];
            end
            pend[g] = exp_q.size();
        end
    end

    task automatic send(input int i, input logic [127:0] d);
        in_data[i]  = d;
        in_valid[i] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                @(posedge clk);
                #1;
                in_valid[i] = 1'b0;
                return;
            end
        end
        fail($sformatf("u%0d_send_timeout", i));
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid[i]) return;
        end
        fail($sformatf("u%0d_out_valid_timeout", i));
    endtask

    task automatic sweep(input int i);
        logic [127:0] d;
        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < 16; b++) d[8 * (15 - b) +: 8] = 8'(s * 16 + b);
            send(i, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        int rx0;
        build_sbox();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
            gap_on[i]    = 1'b0;
            rx_cnt[i]    = 0;
            pend[i]      = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_rst_in_ready", i), 128'(in_ready[i]), 0);
            chk($sformatf("u%0d_rst_out_valid", i), 128'(out_valid[i]), 0);
            chk($sformatf("u%0d_rst_busy", i), 128'(busy[i]), 0);
            chk($sformatf("u%0d_rst_out_data", i), out_data[i], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("u%0d_idle_in_ready", i), 128'(in_ready[i]), 1);

        // Known-answer vector at 4 bytes per cycle.
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        send(0, 128'h00112233445566778899aabbccddeeff);
        wait_valid(0);
        chk("kat_vector", out_data[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
        @(posedge clk);
        #1;

        // Every byte value through the 1- and 16-byte-per-cycle instances.
        out_ready[1] = 1'b1;
        out_ready[2] = 1'b1;
        fork
            sweep(1);
            sweep(2);
        join
        repeat (20) @(posedge clk);
        #1;

        // Backpressure in DONE with new data offered.
        out_ready[0] = 1'b0;
        d = rand128();
        send(0, d);
        wait_valid(0);
        in_data[0]  = rand128();
        in_valid[0] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("hold_out_data", out_data[0], ref_sub(d));
            chk("hold_in_ready", 128'(in_ready[0]), 0);
            chk("hold_out_valid", 128'(out_valid[0]), 1);
        end
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release_in_ready", 128'(in_ready[0]), 1);
        chk("release_out_valid", 128'(out_valid[0]), 0);

        // Reset in the middle of BUSY at chunk 2.
        @(posedge clk);
        #1;
        send(0, rand128());
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 128'(out_valid[0]), 0);
        chk("abort_busy", 128'(busy[0]), 0);
        chk("abort_out_data", out_data[0], 0);
        chk("abort_in_ready_low", 128'(in_ready[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_abort_in_ready", 128'(in_ready[0]), 1);
        chk("after_abort_out_valid", 128'(out_valid[0]), 0);
        @(posedge clk);
        #1;
        send(0, 128'h0);
        wait_valid(0);
        chk("zero_state", out_data[0], {16{8'h63}});
        @(posedge clk);
        #1;

        // Back-to-back stream with the sink always ready.
        gap_on[0] = 1'b1;
        rx0 = rx_cnt[0];
        for (int t = 0; t < 8; t++) send(0, rand128());
        repeat (12) @(posedge clk);
        #1;
        gap_on[0] = 1'b0;
        chk("stream_count", 128'(rx_cnt[0] - rx0), 8);

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("u%0d_queue_empty", i), 128'(pend[i]), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
